// File: rtl/ex_stage_md_pkg.sv
// Shared definitions for the execute stage: default widths, ALU op codes and
// the encoding of the multiply/divide sequencer states.
package ex_stage_md_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ALUC_W_DEF = 5;

   localparam logic [4:0] ALUC_ADD   = 5'd0;
   localparam logic [4:0] ALUC_SUB   = 5'd1;
   localparam logic [4:0] ALUC_AND   = 5'd2;
   localparam logic [4:0] ALUC_OR    = 5'd3;
   localparam logic [4:0] ALUC_XOR   = 5'd4;
   localparam logic [4:0] ALUC_NOR   = 5'd5;
   localparam logic [4:0] ALUC_SLT   = 5'd6;
   localparam logic [4:0] ALUC_SLTU  = 5'd7;
   localparam logic [4:0] ALUC_SLL   = 5'd8;
   localparam logic [4:0] ALUC_SRL   = 5'd9;
   localparam logic [4:0] ALUC_SRA   = 5'd10;
   localparam logic [4:0] ALUC_LUI   = 5'd11;
   localparam logic [4:0] ALUC_MULT  = 5'd12;
   localparam logic [4:0] ALUC_MULTU = 5'd13;
   localparam logic [4:0] ALUC_DIV   = 5'd14;
   localparam logic [4:0] ALUC_DIVU  = 5'd15;
   localparam logic [4:0] ALUC_MFHI  = 5'd16;
   localparam logic [4:0] ALUC_MFLO  = 5'd17;

   // md_kind_t: bit 1 selects divide, bit 0 selects signed operands
   typedef logic [1:0] md_kind_t;
   localparam md_kind_t MD_KIND_MULTU = 2'b00;
   localparam md_kind_t MD_KIND_MULT  = 2'b01;
   localparam md_kind_t MD_KIND_DIVU  = 2'b10;
   localparam md_kind_t MD_KIND_DIV   = 2'b11;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_BUSY = 2'd1,
      MD_DONE = 2'd2
   } md_state_e;

endpackage

// File: rtl/ex_stage_md_md_unit.sv
// Iterative radix-2 multiply / restoring divide on operand magnitudes, with
// sign correction on completion and the architectural HI/LO registers.
module md_unit
   import ex_stage_md_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              flush,
   input  md_kind_t          kind,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output md_state_e         state,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   md_state_e           state_r, state_nxt_s;
   logic [CNT_W-1:0]    cnt_r;
   logic                is_div_r, a_neg_r, b_neg_r, div_zero_r;
   logic [DATA_W-1:0]   a_raw_r, mcand_r, acc_hi_r, acc_lo_r, hi_r, lo_r;
   logic                load_s, step_s, commit_s;
   logic                a_neg_s, b_neg_s;
   logic [DATA_W-1:0]   a_mag_s, b_mag_s;
   logic [DATA_W:0]     mul_sum_s, div_shift_s, div_trial_s;
   logic [DATA_W-1:0]   acc_hi_nxt_s, acc_lo_nxt_s;
   logic [2*DATA_W-1:0] prod_s;
   logic [DATA_W-1:0]   quo_s, rem_s, hi_fix_s, lo_fix_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= MD_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; flush abandons the operation from any state
   always_comb begin
      state_nxt_s = state_r;
      if (flush) begin
         state_nxt_s = MD_IDLE;
      end else begin
         case (state_r)
            MD_IDLE: state_nxt_s = start ? MD_BUSY : MD_IDLE;
            MD_BUSY: state_nxt_s = (cnt_r == {CNT_W{1'b0}}) ? MD_DONE : MD_BUSY;
            MD_DONE: state_nxt_s = MD_IDLE;
            default: state_nxt_s = MD_IDLE;
         endcase
      end
   end

   // Datapath strobes decoded from the current state
   always_comb begin
      load_s   = (state_r == MD_IDLE) && start && !flush;
      step_s   = (state_r == MD_BUSY) && !flush;
      commit_s = (state_r == MD_DONE) && !flush;
   end

   // Operand magnitudes and one radix-2 iteration of either algorithm
   always_comb begin
      a_neg_s      = kind[0] & op_a[DATA_W-1];
      b_neg_s      = kind[0] & op_b[DATA_W-1];
      a_mag_s      = a_neg_s ? -op_a : op_a;
      b_mag_s      = b_neg_s ? -op_b : op_b;
      mul_sum_s    = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, mcand_r} : {(DATA_W+1){1'b0}});
      div_shift_s  = {acc_hi_r, acc_lo_r[DATA_W-1]};
      div_trial_s  = div_shift_s - {1'b0, mcand_r};
      acc_hi_nxt_s = acc_hi_r;
      acc_lo_nxt_s = acc_lo_r;
      if (is_div_r) begin
         if (!div_trial_s[DATA_W]) begin
            acc_hi_nxt_s = div_trial_s[DATA_W-1:0];
            acc_lo_nxt_s = {acc_lo_r[DATA_W-2:0], 1'b1};
         end else begin
            acc_hi_nxt_s = div_shift_s[DATA_W-1:0];
            acc_lo_nxt_s = {acc_lo_r[DATA_W-2:0], 1'b0};
         end
      end else begin
         acc_hi_nxt_s = mul_sum_s[DATA_W:1];
         acc_lo_nxt_s = {mul_sum_s[0], acc_lo_r[DATA_W-1:1]};
      end
   end

   // Sign correction of the finished magnitude result
   always_comb begin
      prod_s   = {acc_hi_r, acc_lo_r};
      quo_s    = acc_lo_r;
      rem_s    = acc_hi_r;
      hi_fix_s = acc_hi_r;
      lo_fix_s = acc_lo_r;
      if (!is_div_r) begin
         if (a_neg_r ^ b_neg_r) begin
            prod_s = -{acc_hi_r, acc_lo_r};
         end else begin
            prod_s = {acc_hi_r, acc_lo_r};
         end
         hi_fix_s = prod_s[2*DATA_W-1:DATA_W];
         lo_fix_s = prod_s[DATA_W-1:0];
      end else if (div_zero_r) begin
         hi_fix_s = a_raw_r;
         lo_fix_s = {DATA_W{1'b1}};
      end else begin
         quo_s    = (a_neg_r ^ b_neg_r) ? -acc_lo_r : acc_lo_r;
         rem_s    = a_neg_r ? -acc_hi_r : acc_hi_r;
         hi_fix_s = rem_s;
         lo_fix_s = quo_s;
      end
   end

   // Operand latch, iteration registers and HI/LO write-back
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r      <= {CNT_W{1'b0}};
         is_div_r   <= 1'b0;
         a_neg_r    <= 1'b0;
         b_neg_r    <= 1'b0;
         div_zero_r <= 1'b0;
         a_raw_r    <= {DATA_W{1'b0}};
         mcand_r    <= {DATA_W{1'b0}};
         acc_hi_r   <= {DATA_W{1'b0}};
         acc_lo_r   <= {DATA_W{1'b0}};
         hi_r       <= {DATA_W{1'b0}};
         lo_r       <= {DATA_W{1'b0}};
      end else begin
         if (load_s) begin
            cnt_r      <= CNT_LAST;
            is_div_r   <= kind[1];
            a_neg_r    <= a_neg_s;
            b_neg_r    <= b_neg_s;
            div_zero_r <= kind[1] & (op_b == {DATA_W{1'b0}});
            a_raw_r    <= op_a;
            acc_hi_r   <= {DATA_W{1'b0}};
            // multiply shifts the multiplier (B) out; divide shifts the dividend (A) out
            mcand_r    <= kind[1] ? b_mag_s : a_mag_s;
            acc_lo_r   <= kind[1] ? a_mag_s : b_mag_s;
         end else if (step_s) begin
            acc_hi_r <= acc_hi_nxt_s;
            acc_lo_r <= acc_lo_nxt_s;
            if (cnt_r != {CNT_W{1'b0}}) begin
               cnt_r <= cnt_r - CNT_ONE;
            end
         end else if (flush) begin
            cnt_r <= {CNT_W{1'b0}};
         end
         if (commit_s) begin
            hi_r <= hi_fix_s;
            lo_r <= lo_fix_s;
         end
      end
   end

   assign state = state_r;
   assign hi    = hi_r;
   assign lo    = lo_r;

endmodule

// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU/shift/LUI, multi-cycle multiply/divide via
// md_unit with a hazard stall request, and the registered EX/MEM boundary.
module ex_stage_md
   import ex_stage_md_pkg::*;
#(
   parameter int DATA_W     = DATA_W_DEF,
   parameter int REG_ADDR_W = 5,
   parameter int ALUC_W     = ALUC_W_DEF,
   parameter int SHAMT_W    = $clog2(DATA_W)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic                  flush,
   input  logic                  exe_write_reg,
   input  logic                  exe_mem_to_reg,
   input  logic                  exe_write_mem,
   input  logic [ALUC_W-1:0]     exe_aluc,
   input  logic                  exe_alu_imm,
   input  logic                  exe_shift,
   input  logic [REG_ADDR_W-1:0] des_r_i,
   input  logic [DATA_W-1:0]     operand_sa,
   input  logic [DATA_W-1:0]     operand_1,
   input  logic [DATA_W-1:0]     operand_imm,
   input  logic [DATA_W-1:0]     operand_2,
   output logic                  stall_req,
   output logic                  out_valid,
   output logic                  m_write_reg,
   output logic                  m_mem_to_reg,
   output logic                  m_write_mem,
   output logic [DATA_W-1:0]     alu_result,
   output logic [REG_ADDR_W-1:0] e_des_r,
   output logic [DATA_W-1:0]     write_mem_val,
   output logic [DATA_W-1:0]     hi,
   output logic [DATA_W-1:0]     lo
);

   logic [DATA_W-1:0]  opb_s, amt_full_s, alu_res_s;
   logic [SHAMT_W-1:0] amt_s;
   logic               amt_unused_s;
   logic               is_md_s, md_start_s;
   md_kind_t           md_kind_s;
   md_state_e          md_state_s;

   // Operand selection and multiply/divide decode
   always_comb begin
      opb_s        = exe_alu_imm ? operand_imm : operand_2;
      amt_full_s   = exe_shift ? operand_sa : operand_1;
      amt_s        = amt_full_s[SHAMT_W-1:0];
      amt_unused_s = ^amt_full_s[DATA_W-1:SHAMT_W];
      is_md_s      = 1'b0;
      md_kind_s    = MD_KIND_MULTU;
      case (exe_aluc)
         ALUC_W'(ALUC_MULT):  begin is_md_s = 1'b1; md_kind_s = MD_KIND_MULT;  end
         ALUC_W'(ALUC_MULTU): begin is_md_s = 1'b1; md_kind_s = MD_KIND_MULTU; end
         ALUC_W'(ALUC_DIV):   begin is_md_s = 1'b1; md_kind_s = MD_KIND_DIV;   end
         ALUC_W'(ALUC_DIVU):  begin is_md_s = 1'b1; md_kind_s = MD_KIND_DIVU;  end
         default:             begin is_md_s = 1'b0; md_kind_s = MD_KIND_MULTU; end
      endcase
   end

   // Single-cycle result; multiply/divide codes fall through to zero here
   always_comb begin
      alu_res_s = {DATA_W{1'b0}};
      case (exe_aluc)
         ALUC_W'(ALUC_ADD):  alu_res_s = operand_1 + opb_s;
         ALUC_W'(ALUC_SUB):  alu_res_s = operand_1 - opb_s;
         ALUC_W'(ALUC_AND):  alu_res_s = operand_1 & opb_s;
         ALUC_W'(ALUC_OR):   alu_res_s = operand_1 | opb_s;
         ALUC_W'(ALUC_XOR):  alu_res_s = operand_1 ^ opb_s;
         ALUC_W'(ALUC_NOR):  alu_res_s = ~(operand_1 | opb_s);
         ALUC_W'(ALUC_SLT):  alu_res_s = {{(DATA_W-1){1'b0}}, ($signed(operand_1) < $signed(opb_s))};
         ALUC_W'(ALUC_SLTU): alu_res_s = {{(DATA_W-1){1'b0}}, (operand_1 < opb_s)};
         ALUC_W'(ALUC_SLL):  alu_res_s = opb_s << amt_s;
         ALUC_W'(ALUC_SRL):  alu_res_s = opb_s >> amt_s;
         ALUC_W'(ALUC_SRA):  alu_res_s = DATA_W'($signed(opb_s) >>> amt_s);
         ALUC_W'(ALUC_LUI):  alu_res_s = opb_s << (DATA_W / 2);
         ALUC_W'(ALUC_MFHI): alu_res_s = hi;
         ALUC_W'(ALUC_MFLO): alu_res_s = lo;
         default:            alu_res_s = {DATA_W{1'b0}};
      endcase
   end

   assign md_start_s = in_valid & is_md_s & ~flush;
   // DONE releases the stall so upstream can advance on the write-back edge
   assign stall_req  = in_valid & is_md_s & (md_state_s != MD_DONE);

   md_unit #(
      .DATA_W (DATA_W)
   ) u_md_unit (
      .clk   (clk),
      .rst   (rst),
      .start (md_start_s),
      .flush (flush),
      .kind  (md_kind_s),
      .op_a  (operand_1),
      .op_b  (opb_s),
      .state (md_state_s),
      .hi    (hi),
      .lo    (lo)
   );

   // EX/MEM boundary registers
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         out_valid     <= 1'b0;
         m_write_reg   <= 1'b0;
         m_mem_to_reg  <= 1'b0;
         m_write_mem   <= 1'b0;
         alu_result    <= {DATA_W{1'b0}};
         e_des_r       <= {REG_ADDR_W{1'b0}};
         write_mem_val <= {DATA_W{1'b0}};
      end else if (md_state_s == MD_DONE) begin
         out_valid     <= 1'b1;
         m_write_reg   <= 1'b0;
         m_mem_to_reg  <= 1'b0;
         m_write_mem   <= 1'b0;
         alu_result    <= {DATA_W{1'b0}};
         e_des_r       <= {REG_ADDR_W{1'b0}};
         write_mem_val <= {DATA_W{1'b0}};
      end else if (in_valid && !is_md_s) begin
         out_valid     <= 1'b1;
         m_write_reg   <= exe_write_reg;
         m_mem_to_reg  <= exe_mem_to_reg;
         m_write_mem   <= exe_write_mem;
         alu_result    <= alu_res_s;
         e_des_r       <= des_r_i;
         write_mem_val <= operand_2;
      end else begin
         out_valid     <= 1'b0;
         m_write_reg   <= 1'b0;
         m_mem_to_reg  <= 1'b0;
         m_write_mem   <= 1'b0;
         alu_result    <= {DATA_W{1'b0}};
         e_des_r       <= {REG_ADDR_W{1'b0}};
         write_mem_val <= {DATA_W{1'b0}};
      end
   end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed self-checking bench for ex_stage_md at DATA_W = 32 with
// hand-computed expected values.
module tb_ex_stage_md;

   logic        clk = 1'b0;
   logic        rst, in_valid, flush;
   logic        exe_write_reg, exe_mem_to_reg, exe_write_mem;
   logic [4:0]  exe_aluc;
   logic        exe_alu_imm, exe_shift;
   logic [4:0]  des_r_i;
   logic [31:0] operand_sa, operand_1, operand_imm, operand_2;
   logic        stall_req, out_valid, m_write_reg, m_mem_to_reg, m_write_mem;
   logic [31:0] alu_result, write_mem_val, hi, lo;
   logic [4:0]  e_des_r;

   int checks = 0;
   int errors = 0;
   int n_stall, n_bubble;

   always #5 clk = ~clk;

   ex_stage_md #(
      .DATA_W(32), .REG_ADDR_W(5), .ALUC_W(5)
   ) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .flush(flush),
      .exe_write_reg(exe_write_reg), .exe_mem_to_reg(exe_mem_to_reg),
      .exe_write_mem(exe_write_mem), .exe_aluc(exe_aluc),
      .exe_alu_imm(exe_alu_imm), .exe_shift(exe_shift), .des_r_i(des_r_i),
      .operand_sa(operand_sa), .operand_1(operand_1), .operand_imm(operand_imm),
      .operand_2(operand_2), .stall_req(stall_req), .out_valid(out_valid),
      .m_write_reg(m_write_reg), .m_mem_to_reg(m_mem_to_reg),
      .m_write_mem(m_write_mem), .alu_result(alu_result), .e_des_r(e_des_r),
      .write_mem_val(write_mem_val), .hi(hi), .lo(lo)
   );

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [4:0] aluc, input logic [31:0] a, input logic [31:0] b);
      in_valid       = 1'b1;
      exe_aluc       = aluc;
      operand_1      = a;
      operand_2      = b;
      operand_imm    = 32'h0;
      operand_sa     = 32'h0;
      exe_alu_imm    = 1'b0;
      exe_shift      = 1'b0;
      exe_write_reg  = 1'b1;
      exe_mem_to_reg = 1'b0;
      exe_write_mem  = 1'b0;
      des_r_i        = 5'd3;
   endtask

   // Count stall cycles of a held MD op; ends in the DONE cycle
   task automatic run_md(output int n, output int bubbles);
      n = 0;
      bubbles = 0;
      #1;
      while (stall_req === 1'b1 && n < 100) begin
         n++;
         if (n >= 2 && out_valid !== 1'b0) bubbles++;
         step();
      end
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      set_op(5'd0, 32'h0, 32'h0);
      in_valid = 1'b0;
      step();
      step();
      check_val("rst_out_valid", {63'h0, out_valid}, 64'h0);
      check_val("rst_alu_result", {32'h0, alu_result}, 64'h0);
      check_val("rst_hilo", {hi, lo}, 64'h0);
      check_val("rst_stall", {63'h0, stall_req}, 64'h0);
      rst = 1'b0;

      // ADD then SUB, one cycle latency each
      set_op(5'd0, 32'd7, 32'hFFFF_FFFD);
      des_r_i = 5'd7;
      step();
      check_val("add_result", {32'h0, alu_result}, 64'h4);
      check_val("add_valid_wr_des", {61'h0, out_valid, m_write_reg, (e_des_r == 5'd7)}, 64'h7);
      set_op(5'd1, 32'd5, 32'd9);
      exe_write_reg = 1'b0;
      exe_write_mem = 1'b1;
      step();
      check_val("sub_result", {32'h0, alu_result}, 64'hFFFF_FFFC);
      check_val("sub_store", {30'h0, m_write_reg, m_write_mem, write_mem_val}, 64'h1_0000_0009);

      set_op(5'd6, 32'hFFFF_FFFF, 32'd1);
      step();
      check_val("slt_result", {32'h0, alu_result}, 64'h1);
      set_op(5'd7, 32'hFFFF_FFFF, 32'd1);
      step();
      check_val("sltu_result", {32'h0, alu_result}, 64'h0);

      // SRA amount taken from operand_sa; operand_1 would give a different answer
      set_op(5'd10, 32'h0000_0010, 32'h8000_0000);
      exe_shift  = 1'b1;
      operand_sa = 32'd4;
      step();
      check_val("sra_result", {32'h0, alu_result}, 64'hF800_0000);
      set_op(5'd11, 32'h0, 32'h0000_FFFF);
      exe_alu_imm = 1'b1;
      operand_imm = 32'h0000_1234;
      step();
      check_val("lui_result", {32'h0, alu_result}, 64'h1234_0000);
      set_op(5'd20, 32'd5, 32'd6);
      step();
      check_val("undef_op", {31'h0, out_valid, alu_result}, 64'h1_0000_0000);
      in_valid = 1'b0;
      step();
      check_val("idle_bubble", {31'h0, out_valid, alu_result}, 64'h0);

      // MULT -3 * 5
      set_op(5'd12, 32'hFFFF_FFFD, 32'd5);
      run_md(n_stall, n_bubble);
      check_val("mult_stall_cycles", 64'(n_stall), 64'd33);
      check_val("mult_bubbles", 64'(n_bubble), 64'd0);
      step();
      check_val("mult_done_ctl", {60'h0, out_valid, m_write_reg, m_mem_to_reg, m_write_mem}, 64'h8);
      check_val("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
      set_op(5'd17, 32'h0, 32'h0);
      step();
      check_val("mflo_after_mult", {32'h0, alu_result}, 64'hFFFF_FFF1);
      set_op(5'd16, 32'h0, 32'h0);
      step();
      check_val("mfhi_after_mult", {32'h0, alu_result}, 64'hFFFF_FFFF);

      set_op(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run_md(n_stall, n_bubble);
      step();
      check_val("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);

      set_op(5'd14, 32'hFFFF_FFF9, 32'd2);
      run_md(n_stall, n_bubble);
      step();
      check_val("div_neg_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      set_op(5'd15, 32'd10, 32'd0);
      run_md(n_stall, n_bubble);
      step();
      check_val("divu_zero_hilo", {hi, lo}, 64'h0000_000A_FFFF_FFFF);
      set_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF);
      run_md(n_stall, n_bubble);
      step();
      check_val("div_min_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

      // Flush on the tenth BUSY cycle of a MULTU
      set_op(5'd13, 32'd3, 32'd4);
      repeat (10) step();
      check_val("busy_stall", {63'h0, stall_req}, 64'h1);
      flush    = 1'b1;
      in_valid = 1'b0;
      step();
      flush = 1'b0;
      check_val("flush_stall_valid", {62'h0, stall_req, out_valid}, 64'h0);
      check_val("flush_hilo_kept", {hi, lo}, 64'h0000_0000_8000_0000);
      repeat (40) step();
      check_val("flush_no_late_write", {31'h0, out_valid, lo}, 64'h0000_0000_8000_0000);

      // Reset in the middle of a MULT; an ADD is presented alongside rst
      set_op(5'd12, 32'hFFFF_FFFD, 32'd5);
      repeat (5) step();
      set_op(5'd0, 32'd1, 32'd1);
      rst = 1'b1;
      step();
      check_val("rst_mid_out", {31'h0, out_valid, alu_result}, 64'h0);
      check_val("rst_mid_hilo", {hi, lo}, 64'h0);
      check_val("rst_mid_misc", {22'h0, m_write_reg, m_mem_to_reg, m_write_mem, e_des_r, write_mem_val}, 64'h0);
      rst = 1'b0;
      in_valid = 1'b0;
      step();
      check_val("rst_mid_stall", {63'h0, stall_req}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
